mul_div_seq: RTL



---
 rtl/mul_div_seq_pkg.sv | 21 ++
 rtl/md_step.sv | 33 +++
 rtl/mul_div_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mul_div_seq_pkg.sv
// Shared constants and encodings for the iterative HI/LO multiply/divide unit.
// Optional early-terminating multiply is selected with MD_EARLY_TERM_EN.
package mul_div_seq_pkg;

  localparam int MD_XLEN = 32;
  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// Operates on unsigned magnitudes; sign handling lives in the caller.
module md_step #(
  parameter int XLEN = 32
) (
  input  logic            div,
  input  logic [XLEN-1:0] part_hi,
  input  logic [XLEN-1:0] part_lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] next_hi,
  output logic [XLEN-1:0] next_lo
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shl;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum  = {1'b0, part_hi} + (part_lo[0] ? {1'b0, opnd} : '0);
    shl  = {part_hi, part_lo[XLEN-1]};
    ge   = (shl >= {1'b0, opnd});
    diff = shl[XLEN-1:0] - opnd;
    if (div) begin
      next_hi = ge ? diff : shl[XLEN-1:0];
      next_lo = {part_lo[XLEN-2:0], ge};
    end else begin
      next_hi = sum[XLEN:1];
      next_lo = {sum[0], part_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_seq.sv
// Iterative MIPS32 HI/LO unit: MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Define MD_EARLY_TERM_EN to let multiplies stop once the multiplier is exhausted.
module mul_div_seq
  import mul_div_seq_pkg::*;
#(
  parameter int XLEN = MD_XLEN,
  parameter int ITER = MD_ITER
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Start,
  input  logic [1:0]      Op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            HiWe,
  input  logic            LoWe,
  input  logic [XLEN-1:0] WrData,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo
);

  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] ITER_C = CW'(ITER);

  md_state_e state, state_nx;

  logic [CW-1:0]     cnt, cnt_nx;
  logic              is_div, neg_res, neg_rem;
  logic [XLEN-1:0]   acc_hi, acc_lo, opnd;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic              last;
  logic              dv, sgn, bz, sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo, rem, res_hi, res_lo;

`ifdef MD_EARLY_TERM_EN
  logic [XLEN-1:0]   rest;
`endif

  md_step #(.XLEN(XLEN)) u_step (
    .div     (is_div),
    .part_hi (acc_hi),
    .part_lo (acc_lo),
    .opnd    (opnd),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // Divide by zero keeps raw operands so the datapath yields Hi=A, Lo=~0.
  always_comb begin
    dv    = (Op == MD_DIV) || (Op == MD_DIVU);
    sgn   = (Op == MD_MULT) || (Op == MD_DIV);
    bz    = (B == '0);
    sa    = sgn & A[XLEN-1] & ~(dv & bz);
    sb    = sgn & B[XLEN-1] & ~(dv & bz);
    a_mag = sa ? -A : A;
    b_mag = sb ? -B : B;
  end

  always_comb begin
    cnt_nx = cnt + 1'b1;
`ifdef MD_EARLY_TERM_EN
    last = (cnt_nx == ITER_C) ||
           (!is_div && ((rest >> 1) == '0));
`else
    last = (cnt_nx == ITER_C);
`endif
  end

  // An early-terminated product still needs its remaining right shifts.
  always_comb begin
    prod     = {acc_hi, acc_lo} >> (ITER_C - cnt);
    prod_fix = neg_res ? -prod : prod;
    quo      = neg_res ? -acc_lo : acc_lo;
    rem      = neg_rem ? -acc_hi : acc_hi;
    if (is_div) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod_fix[2*XLEN-1:XLEN];
      res_lo = prod_fix[XLEN-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    Busy     = (state != MD_IDLE);
    unique case (state)
      MD_IDLE: if (Start) state_nx = MD_RUN;
      MD_RUN:  if (last) state_nx = MD_FIX;
      MD_FIX:  state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= MD_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Done    <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
`ifdef MD_EARLY_TERM_EN
      rest    <= '0;
`endif
    end else begin
      Done <= (state == MD_FIX);
      unique case (state)
        MD_IDLE: begin
          if (HiWe) Hi <= WrData;
          if (LoWe) Lo <= WrData;
          if (Start) begin
            is_div  <= dv;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            acc_hi  <= '0;
            acc_lo  <= dv ? a_mag : b_mag;
            opnd    <= dv ? b_mag : a_mag;
            cnt     <= '0;
`ifdef MD_EARLY_TERM_EN
            rest    <= b_mag;
`endif
          end
        end
        MD_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt_nx;
`ifdef MD_EARLY_TERM_EN
          rest   <= rest >> 1;
`endif
        end
        MD_FIX: begin
          Hi <= res_hi;
          Lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
